// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I sequencer. One memory access per state,
// shared instruction/data port, retired-instruction counter, halt on illegal
// opcode or memory timeout.
//
// Memory handshake: mem_req is held high from the first cycle of an access
// until the cycle in which mem_ready is sampled high. That cycle completes
// the access, and read data is valid in it. mem_ready is ignored whenever
// mem_req is low. Reset drops mem_req at once, and no completion is owed.
module multicycle_ctrl #(
    parameter int DW       = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] instr,
    input  logic          eq,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic          addr_sel,
    output logic          ir_we,
    output logic          pc_we,
    output logic          pc_sel,
    output logic          reg_we,
    output logic [1:0]    wd_sel,
    output logic          alu_src,
    output logic [2:0]    alu_ctrl,
    output logic [2:0]    imm_src,
    output logic          halted,
    output logic [1:0]    fault,
    output logic [31:0]   instret
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    fault_q, fault_d;
    logic [31:0]   instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       dec_legal, is_alu, is_lw, is_sw, is_br, is_jal;
    logic       dec_alu_src;
    logic [2:0] dec_alu_ctrl, dec_imm_src;
    logic       br_taken;
    logic       retire;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[DW-1:31], instr[29:15], instr[11:7]};
    assign br_taken     = ((funct3 == 3'b000) && eq) || ((funct3 == 3'b001) && !eq);

    // Instruction decode: class flags, legality and ALU/immediate selects.
    always_comb begin
        dec_legal    = 1'b0;
        is_alu       = 1'b0;
        is_lw        = 1'b0;
        is_sw        = 1'b0;
        is_br        = 1'b0;
        is_jal       = 1'b0;
        dec_alu_src  = 1'b0;
        dec_alu_ctrl = ALU_ADD;
        dec_imm_src  = IMM_I;
        case (opcode)
            OP_R, OP_I: begin
                is_alu      = 1'b1;
                dec_alu_src = (opcode == OP_I);
                dec_legal   = 1'b1;
                case (funct3)
                    // instr[30] selects sub only for register-register ops.
                    3'b000:  dec_alu_ctrl = ((opcode == OP_R) && instr[30]) ? ALU_SUB : ALU_ADD;
                    3'b111:  dec_alu_ctrl = ALU_AND;
                    3'b110:  dec_alu_ctrl = ALU_OR;
                    3'b010:  dec_alu_ctrl = ALU_SLT;
                    default: dec_legal    = 1'b0;
                endcase
            end
            OP_LW: begin
                is_lw       = 1'b1;
                dec_legal   = (funct3 == 3'b010);
                dec_alu_src = 1'b1;
            end
            OP_SW: begin
                is_sw       = 1'b1;
                dec_legal   = (funct3 == 3'b010);
                dec_alu_src = 1'b1;
                dec_imm_src = IMM_S;
            end
            OP_BR: begin
                is_br        = 1'b1;
                dec_legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec_alu_ctrl = ALU_SUB;
                dec_imm_src  = IMM_B;
            end
            OP_JAL: begin
                is_jal      = 1'b1;
                dec_legal   = 1'b1;
                dec_imm_src = IMM_J;
            end
            default: ;
        endcase
    end

    // Next-state, wait counter, fault capture and all datapath strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        fault_d   = fault_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        reg_we    = 1'b0;
        wd_sel    = 2'b00;
        alu_src   = 1'b0;
        alu_ctrl  = 3'b000;
        imm_src   = 3'b000;
        halted    = 1'b0;

        if (state_q == S_DECODE || state_q == S_EXEC || state_q == S_MEM) begin
            alu_src  = dec_alu_src;
            alu_ctrl = dec_alu_ctrl;
            imm_src  = dec_imm_src;
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (cnt_q == CW'(WAIT_MAX)) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_HALT;
                    fault_d = FAULT_ILLEGAL;
                end
            end
            S_EXEC: begin
                // Legality is re-checked in case the instruction changed.
                if (!dec_legal) begin
                    state_d = S_HALT;
                    fault_d = FAULT_ILLEGAL;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                    pc_we   = 1'b1;
                    if (is_alu) begin
                        reg_we = 1'b1;
                    end else if (is_br) begin
                        pc_sel = br_taken;
                    end else if (is_jal) begin
                        reg_we = 1'b1;
                        wd_sel = 2'b10;
                        pc_sel = 1'b1;
                    end
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_sw;
                if (mem_ready) begin
                    reg_we  = is_lw;
                    wd_sel  = is_lw ? 2'b01 : 2'b00;
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (cnt_q == CW'(WAIT_MAX)) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_IDLE;
        endcase

        instret_d = instret_q + {31'd0, retire};
    end

    // State, counters and fault register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            fault_q   <= FAULT_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    assign fault   = fault_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-instruction reference model builds the
// expected cycle-by-cycle strobe trace, a driver replays it, and each test
// task compares the observed trace against the expected queue.
module tb_multicycle_ctrl;

    localparam int DW       = 32;
    localparam int WAIT_MAX = 15;
    localparam int VW       = 19;
    localparam logic [VW-1:0] FULL     = '1;
    localparam logic [VW-1:0] FLD_BITS = 19'h003F8;

    localparam logic [2:0] K_ALU = 3'd0;
    localparam logic [2:0] K_LW  = 3'd1;
    localparam logic [2:0] K_SW  = 3'd2;
    localparam logic [2:0] K_BR  = 3'd3;
    localparam logic [2:0] K_JAL = 3'd4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] instr = '0;
    logic          eq = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we;
    logic [1:0]    wd_sel;
    logic          alu_src;
    logic [2:0]    alu_ctrl, imm_src;
    logic          halted;
    logic [1:0]    fault;
    logic [31:0]   instret;

    multicycle_ctrl #(.DW(DW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wd_sel(wd_sel),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .halted(halted), .fault(fault), .instret(instret)
    );

    // Clock
    always #5 clk = ~clk;

    logic [VW-1:0] out_vec;
    assign out_vec = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we,
                      wd_sel, alu_src, alu_ctrl, imm_src, halted, fault};

    int n_cmp = 0;
    int n_err = 0;
    logic [VW+31:0] exp_q[$];
    logic [VW-1:0]  msk_q[$];
    logic [33:0]    stim_q[$];
    logic [VW+31:0] obs_q[$];
    logic [31:0]    exp_instret;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [VW-1:0] mk(input logic req, input logic we, input logic asel,
                                         input logic irwe, input logic pcwe, input logic pcsel,
                                         input logic rwe, input logic [1:0] wds,
                                         input logic [6:0] fld, input logic hl,
                                         input logic [1:0] flt);
        return {req, we, asel, irwe, pcwe, pcsel, rwe, wds, fld, hl, flt};
    endfunction

    // Reference decode by mnemonic: {legal, kind, {alu_src, alu_ctrl, imm_src}}
    function automatic logic [10:0] ref_decode(input logic [31:0] ins);
        logic [2:0] f3;
        logic [2:0] op;
        logic       ok;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33, 7'h13: begin
                ok = 1'b1;
                op = 3'b000;
                if (f3 == 3'b000)      op = (ins[6:0] == 7'h33 && ins[30]) ? 3'b001 : 3'b000;
                else if (f3 == 3'b111) op = 3'b010;
                else if (f3 == 3'b110) op = 3'b011;
                else if (f3 == 3'b010) op = 3'b101;
                else                   ok = 1'b0;
                return {ok, K_ALU, (ins[6:0] == 7'h13), op, 3'b000};
            end
            7'h03:   return {(f3 == 3'b010), K_LW,  1'b1, 3'b000, 3'b000};
            7'h23:   return {(f3 == 3'b010), K_SW,  1'b1, 3'b000, 3'b001};
            7'h63:   return {(f3 == 3'b000 || f3 == 3'b001), K_BR, 1'b0, 3'b001, 3'b010};
            7'h6F:   return {1'b1, K_JAL, 1'b0, 3'b000, 3'b011};
            default: return 11'd0;
        endcase
    endfunction

    function automatic logic [31:0] rand_legal();
        logic [31:0] ins;
        logic [2:0]  f3;
        int          k;
        logic [2:0]  alu_f3[4];
        alu_f3 = '{3'b000, 3'b111, 3'b110, 3'b010};
        ins = $urandom;
        k   = $urandom_range(0, 5);
        f3  = alu_f3[$urandom_range(0, 3)];
        case (k)
            0: begin
                ins[6:0] = 7'h33; ins[14:12] = f3;
                ins[31:25] = {1'b0, (f3 == 3'b000) ? rbit() : 1'b0, 5'd0};
            end
            1: begin ins[6:0] = 7'h13; ins[14:12] = f3; end
            2: begin ins[6:0] = 7'h03; ins[14:12] = 3'b010; end
            3: begin ins[6:0] = 7'h23; ins[14:12] = 3'b010; end
            4: begin ins[6:0] = 7'h63; ins[14:12] = {2'b00, rbit()}; end
            default: ins[6:0] = 7'h6F;
        endcase
        return ins;
    endfunction

    task automatic push(input logic [31:0] ins, input logic e, input logic r,
                        input logic [VW-1:0] v, input logic [VW-1:0] m);
        stim_q.push_back({ins, e, r});
        exp_q.push_back({exp_instret, v});
        msk_q.push_back(m);
    endtask

    task automatic push_halt(input logic [31:0] ins, input logic [1:0] f);
        for (int i = 0; i < 4; i++)
            push(ins, rbit(), rbit(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 7'h0, 1'b1, f), FULL);
    endtask

    // Expected trace of one instruction starting in FETCH; fw/mw are the
    // number of cycles mem_ready stays low in FETCH/MEM.
    task automatic build_instr(input logic [31:0] ins, input logic e, input int fw, input int mw);
        logic [10:0] d;
        logic [6:0]  f;
        logic        taken;
        logic        sw_i;
        logic        lw_i;
        d    = ref_decode(ins);
        f    = d[6:0];
        sw_i = (d[9:7] == K_SW);
        lw_i = (d[9:7] == K_LW);
        for (int i = 0; i < fw && i <= WAIT_MAX; i++)
            push(ins, e, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 7'h0, 0, 2'b00), FULL);
        if (fw > WAIT_MAX) begin push_halt(ins, 2'b10); return; end
        push(ins, e, 1'b1, mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 7'h0, 0, 2'b00), FULL);
        if (!d[10]) begin
            push(ins, e, rbit(), '0, FULL & ~FLD_BITS);
            push_halt(ins, 2'b01);
            return;
        end
        push(ins, e, rbit(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00, f, 0, 2'b00), FULL);
        case (d[9:7])
            K_ALU: begin
                push(ins, e, rbit(), mk(0, 0, 0, 0, 1, 0, 1, 2'b00, f, 0, 2'b00), FULL);
                exp_instret++;
            end
            K_BR: begin
                taken = (ins[14:12] == 3'b000) ? e : !e;
                push(ins, e, rbit(), mk(0, 0, 0, 0, 1, taken, 0, 2'b00, f, 0, 2'b00), FULL);
                exp_instret++;
            end
            K_JAL: begin
                push(ins, e, rbit(), mk(0, 0, 0, 0, 1, 1, 1, 2'b10, f, 0, 2'b00), FULL);
                exp_instret++;
            end
            default: begin
                push(ins, e, rbit(), mk(0, 0, 0, 0, 0, 0, 0, 2'b00, f, 0, 2'b00), FULL);
                for (int i = 0; i < mw && i <= WAIT_MAX; i++)
                    push(ins, e, 1'b0, mk(1, sw_i, 1, 0, 0, 0, 0, 2'b00, f, 0, 2'b00), FULL);
                if (mw > WAIT_MAX) begin push_halt(ins, 2'b10); return; end
                push(ins, e, 1'b1, mk(1, sw_i, 1, 0, 1, 0, lw_i, lw_i ? 2'b01 : 2'b00, f, 0, 2'b00), FULL);
                exp_instret++;
            end
        endcase
    endtask

    // Driver: one queued stimulus per cycle, observation recorded mid-low-phase.
    task automatic drive(input int n);
        logic [33:0] s;
        for (int k = 0; k < n && stim_q.size() > 0; k++) begin
            s = stim_q.pop_front();
            @(negedge clk);
            instr     = s[33:2];
            eq        = s[1];
            mem_ready = s[0];
            #2;
            obs_q.push_back({instret, out_vec});
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        instr = '0; eq = 1'b0; mem_ready = 1'b0;
        stim_q.delete(); exp_q.delete(); msk_q.delete(); obs_q.delete();
        exp_instret = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        push(32'h0, rbit(), rbit(), '0, FULL);  // IDLE cycle
    endtask

    task automatic test_reset();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        int c = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_vec !== '0 || instret !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async: got out=%05h instret=%0d, expected out=00000 instret=0", out_vec, instret);
        end
        apply_reset();
        build_instr(32'h00500093, rbit(), 0, 0);  // addi x1,x0,5
        build_instr(32'h002081B3, rbit(), 0, 0);  // add
        build_instr(32'h402081B3, rbit(), 1, 0);  // sub
        build_instr(32'h0020F1B3, rbit(), 0, 0);  // and
        drive(stim_q.size());
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
            n_cmp++;
            if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                n_err++;
                $display("FAIL reset_alu cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                         c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
            end
            c++;
        end
    endtask

    task automatic test_branch();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        int c = 0;
        apply_reset();
        build_instr(32'h00209463, 1'b0, 0, 0);  // bne taken
        build_instr(32'h00209463, 1'b1, 0, 0);  // bne not taken
        build_instr(32'h00208463, 1'b1, 0, 0);  // beq taken
        build_instr(32'h00208463, 1'b0, 2, 0);  // beq not taken
        build_instr(32'h0080006F, rbit(), 0, 0);  // jal
        drive(stim_q.size());
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
            n_cmp++;
            if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                n_err++;
                $display("FAIL branch cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                         c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
            end
            c++;
        end
    endtask

    task automatic test_load_store();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        int c = 0;
        apply_reset();
        build_instr(32'h00002083, rbit(), 0, 3);         // lw, 3 wait cycles
        build_instr(32'h00112023, rbit(), 0, 0);         // sw, zero wait
        build_instr(32'h00402103, rbit(), 0, WAIT_MAX);  // lw, ready on last allowed cycle
        build_instr(32'h00112223, rbit(), WAIT_MAX, 1);  // sw, fetch at the limit
        drive(stim_q.size());
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
            n_cmp++;
            if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                n_err++;
                $display("FAIL load_store cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                         c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
            end
            c++;
        end
    endtask

    task automatic test_timeout();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        int c = 0;
        for (int sc = 0; sc < 2; sc++) begin
            apply_reset();
            if (sc == 0) begin
                build_instr(32'h00500093, rbit(), 0, 0);
                build_instr(32'h00112023, rbit(), 0, WAIT_MAX + 1);  // sw never ready
            end else begin
                build_instr(32'h00002083, rbit(), WAIT_MAX + 1, 0);  // fetch never ready
            end
            drive(stim_q.size());
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
                n_cmp++;
                if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                    n_err++;
                    $display("FAIL timeout sc%0d cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                             sc, c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
                end
                c++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        logic [31:0]    bad[5];
        int c = 0;
        bad = '{32'hFFFFFFFF, 32'h0020A463, 32'h00001033, 32'h00001013, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            build_instr(bad[i], rbit(), 0, 0);
            drive(stim_q.size());
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
                n_cmp++;
                if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                    n_err++;
                    $display("FAIL illegal %08h cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                             bad[i], c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
                end
                c++;
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        int c = 0;
        for (int ph = 0; ph < 2; ph++) begin
            apply_reset();
            build_instr(32'h00500093, rbit(), 0, 0);
            if (ph == 0) begin
                build_instr(32'h00112023, rbit(), 0, 10);
                drive(10);  // IDLE, addi, sw up to its third MEM wait cycle
            end else begin
                drive(stim_q.size());
            end
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
                n_cmp++;
                if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                    n_err++;
                    $display("FAIL reset_mid_mem ph%0d cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                             ph, c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
                end
                c++;
            end
            if (ph == 0) begin
                #1 rst = 1'b1;
                #1;
                n_cmp++;
                if (mem_req !== 1'b0 || mem_we !== 1'b0 || out_vec !== '0 || instret !== 32'd0) begin
                    n_err++;
                    $display("FAIL reset_mid_mem_async: got mem_req=%b mem_we=%b out=%05h instret=%0d, expected all 0",
                             mem_req, mem_we, out_vec, instret);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [VW+31:0] o, e;
        logic [VW-1:0]  m;
        int c = 0;
        int fw, mw;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            fw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : $urandom_range(0, 3);
            build_instr(rand_legal(), rbit(), fw, mw);
        end
        drive(stim_q.size());
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
            n_cmp++;
            if (((o[VW-1:0] & m) !== (e[VW-1:0] & m)) || (o[VW+31:VW] !== e[VW+31:VW])) begin
                n_err++;
                $display("FAIL random cycle %0d: got out=%05h instret=%0d, expected out=%05h instret=%0d",
                         c, o[VW-1:0], o[VW+31:VW], e[VW-1:0], e[VW+31:VW]);
            end
            c++;
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_load_store();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
